// File: rtl/dmem_pkg.sv
// Shared FSM state type, counter width and byte-lane helpers for the
// data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_t;

  localparam int DM_CNT_W = 4;

  // ARM unaligned LDR: the aligned word is rotated right by whole bytes.
  function automatic logic [31:0] rotr_lanes(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] res;
    case (lane)
      2'd0:    res = word;
      2'd1:    res = {word[7:0], word[31:8]};
      2'd2:    res = {word[15:0], word[31:16]};
      default: res = {word[23:0], word[31:24]};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] byte_extract(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'h000000, b};
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte write enables and a combinational read
// port; contents are deliberately not reset.
module dmem_byte_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-3:0] index_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[index_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency data-memory responder: one load/store in flight, committed to
// RAM on the WAIT->RESP edge, response held until the requester takes it.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic        req_byte_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam logic [DM_CNT_W-1:0] CNT_INIT = DM_CNT_W'(LATENCY - 1);

  dm_state_t           state_q, state_d;
  logic [DM_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic                we_q, we_d, byte_q, byte_d;
  logic                resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic        accept, commit, resp_done, out_of_range;
  logic [1:0]  lane;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, load_data;

  assign lane         = addr_q[1:0];
  assign out_of_range = |addr_q[31:ADDR_WIDTH];
  assign accept       = req_valid_i && req_ready_o;
  assign commit       = (state_q == DM_WAIT) && (cnt_q == '0);
  assign resp_done    = resp_valid_q && resp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= DM_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DM_IDLE: if (accept)         state_d = DM_WAIT;
      DM_WAIT: if (cnt_q == '0)    state_d = DM_RESP;
      DM_RESP: if (resp_ready_i)   state_d = DM_IDLE;
      default:                     state_d = DM_IDLE;
    endcase
  end

  // Ready is suppressed while reset is asserted, not just after it releases.
  always_comb begin
    req_ready_o = 1'b0;
    if (rst_ni && state_q == DM_IDLE) req_ready_o = 1'b1;
  end

  assign ram_we    = commit && we_q && !out_of_range;
  assign ram_be    = byte_q ? lane_mask(lane) : 4'hF;
  assign ram_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;

  dmem_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (clk_i),
    .index_i (addr_q[ADDR_WIDTH-1:2]),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    load_data = '0;
    if (!out_of_range && !we_q) begin
      load_data = byte_q ? byte_extract(ram_rdata, lane) : rotr_lanes(ram_rdata, lane);
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    byte_d       = byte_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
      we_d    = req_we_i;
      byte_d  = req_byte_i;
      cnt_d   = CNT_INIT;
    end else if (state_q == DM_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (commit) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = load_data;
      resp_err_d   = out_of_range;
    end else if (resp_done) begin
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a byte-level model.
module tb_data_memory_responder;

  localparam int ADDR_WIDTH = 12;
  localparam int LATENCY    = 2;
  localparam int MEM_BYTES  = 2 ** ADDR_WIDTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errCount   = 0;
  int checkCount = 0;
  bit randReady  = 1'b0;

  data_memory_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_we_i     (req_we),
    .req_byte_i   (req_byte),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop so a wedged handshake can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached (errors=%0d)", errCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: memory is a flat byte array, timing is tracked as cycle
  // numbers (accept edge + LATENCY = response edge) rather than FSM states.
  logic [7:0]  mByte [MEM_BYTES];
  bit          mKnown [MEM_BYTES];
  bit          mOutstanding, mRespValid, mErr;
  bit          mDataKnown = 1'b1;
  logic [31:0] mRdata = '0;
  logic [31:0] mAddr, mWdata;
  bit          mWe, mByteOp;
  longint      cyc = 0;
  longint      mAcceptCyc = 0;

  task automatic modelCommit();
    int a, base, k;
    a          = int'(mAddr[ADDR_WIDTH-1:0]);
    base       = a & ~3;
    mErr       = (mAddr >= 32'(MEM_BYTES));
    mRdata     = '0;
    mDataKnown = 1'b1;
    if (!mErr) begin
      if (mWe && mByteOp) begin
        mByte[a]  = mWdata[7:0];
        mKnown[a] = 1'b1;
      end else if (mWe) begin
        for (int i = 0; i < 4; i++) begin
          mByte[base+i]  = mWdata[8*i +: 8];
          mKnown[base+i] = 1'b1;
        end
      end else if (mByteOp) begin
        mRdata     = {24'h0, mByte[a]};
        mDataKnown = mKnown[a];
      end else begin
        for (int i = 0; i < 4; i++) begin
          k = base + ((a - base + i) % 4);
          mRdata[8*i +: 8] = mByte[k];
          if (!mKnown[k]) mDataKnown = 1'b0;
        end
      end
    end
  endtask

  // Advance the model at each clock edge; an asynchronous reset drops any
  // pending request or held response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOutstanding = 1'b0;
      mRespValid   = 1'b0;
      mRdata       = '0;
      mErr         = 1'b0;
      mDataKnown   = 1'b1;
    end else begin
      cyc++;
      if (mRespValid) begin
        if (resp_ready) begin
          mRespValid   = 1'b0;
          mOutstanding = 1'b0;
          mRdata       = '0;
          mErr         = 1'b0;
          mDataKnown   = 1'b1;
        end
      end else if (mOutstanding) begin
        if (cyc == mAcceptCyc + LATENCY) begin
          modelCommit();
          mRespValid = 1'b1;
        end
      end else if (req_valid) begin
        mOutstanding = 1'b1;
        mAcceptCyc   = cyc;
        mAddr        = req_addr;
        mWdata       = req_wdata;
        mWe          = req_we;
        mByteOp      = req_byte;
      end
    end
  end

  // Every cycle out of reset, compare all DUT outputs with the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("req_ready", {31'h0, req_ready}, {31'h0, !mOutstanding});
      checkOutput("resp_valid", {31'h0, resp_valid}, {31'h0, mRespValid});
      checkOutput("resp_err", {31'h0, resp_err}, {31'h0, mErr});
      if (mDataKnown) checkOutput("resp_rdata", resp_rdata, mRdata);
    end
  end

  // Random backpressure on the response channel during the random phase.
  always @(negedge clk) begin
    if (randReady) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // Present a request and return #1 after the edge on which it was accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input bit we, input bit bt);
    int n = 0;
    req_addr  = addr;
    req_wdata = wdata;
    req_we    = we;
    req_byte  = bt;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response, report its data and latency, then for the handshake.
  task automatic waitResp(output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) break;
    end
    if (!resp_valid) checkOutput("resp_timeout", 32'h0, 32'h1);
    lat   = n;
    rdata = resp_rdata;
    err   = resp_err;
    n = 0;
    while (resp_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (resp_valid) checkOutput("handshake_timeout", 32'h1, 32'h0);
  endtask

  task automatic doOp(input logic [31:0] addr, input logic [31:0] wdata, input bit we, input bit bt,
                      output logic [31:0] rdata, output logic err, output int lat);
    applyStimulus(addr, wdata, we, bt);
    waitResp(rdata, err, lat);
  endtask

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic [31:0] addr;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset_resp_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_ready", {31'h0, req_ready}, 32'h1);

    // Word store then load, with latency check.
    doOp(32'h100, 32'hDEADBEEF, 1'b1, 1'b0, rd, er, lat);
    checkOutput("t1_store_latency", 32'(lat), 32'(LATENCY));
    checkOutput("t1_store_rdata", rd, 32'h0);
    checkOutput("t1_store_err", {31'h0, er}, 32'h0);
    doOp(32'h100, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t1_load_rdata", rd, 32'hDEADBEEF);

    // Byte store into one lane.
    doOp(32'h100, 32'h11223344, 1'b1, 1'b0, rd, er, lat);
    doOp(32'h102, 32'h777777A5, 1'b1, 1'b1, rd, er, lat);
    doOp(32'h100, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t2_word_after_byte", rd, 32'h11A53344);
    doOp(32'h102, 32'h0, 1'b0, 1'b1, rd, er, lat);
    checkOutput("t2_byte_load", rd, 32'h000000A5);

    // Unaligned word loads rotate.
    doOp(32'h100, 32'h11223344, 1'b1, 1'b0, rd, er, lat);
    doOp(32'h101, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t3_rot_lane1", rd, 32'h44112233);
    doOp(32'h103, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t3_rot_lane3", rd, 32'h22334411);

    // Response stall: held outputs, busy ignores a second request.
    #1 resp_ready = 1'b0;
    applyStimulus(32'h100, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_addr  = 32'h101;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t4_stall_valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("t4_stall_rdata", resp_rdata, 32'h11223344);
      checkOutput("t4_stall_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_hs_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("t4_hs_rdata", resp_rdata, 32'h0);
    checkOutput("t4_idle_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("t4_second_accepted", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b0;
    waitResp(rd, er, lat);
    checkOutput("t4_second_latency", 32'(lat), 32'(LATENCY));
    checkOutput("t4_second_rdata", rd, 32'h44112233);

    // Address range boundary.
    doOp(32'h000, 32'h0BADF00D, 1'b1, 1'b0, rd, er, lat);
    doOp(32'h1000, 32'h99999999, 1'b1, 1'b0, rd, er, lat);
    checkOutput("t5_oor_store_err", {31'h0, er}, 32'h1);
    checkOutput("t5_oor_store_rdata", rd, 32'h0);
    doOp(32'h000, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t5_ram_unchanged", rd, 32'h0BADF00D);
    doOp(32'hFFC, 32'h55AA55AA, 1'b1, 1'b0, rd, er, lat);
    doOp(32'hFFC, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t5_last_word_err", {31'h0, er}, 32'h0);
    checkOutput("t5_last_word_rdata", rd, 32'h55AA55AA);
    doOp(32'h1000, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t5_oor_load_err", {31'h0, er}, 32'h1);

    // Reset during WAIT drops the pending store.
    doOp(32'h200, 32'h12345678, 1'b1, 1'b0, rd, er, lat);
    applyStimulus(32'h200, 32'hCAFEF00D, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("t6_rst_rdata", resp_rdata, 32'h0);
    checkOutput("t6_rst_err", {31'h0, resp_err}, 32'h0);
    checkOutput("t6_rst_ready", {31'h0, req_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doOp(32'h200, 32'h0, 1'b0, 1'b0, rd, er, lat);
    checkOutput("t6_store_dropped", rd, 32'h12345678);

    // Reset during RESP discards the held response.
    resp_ready = 1'b0;
    applyStimulus(32'h200, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t6_resp_held", resp_rdata, 32'h12345678);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_resp_discarded", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with response backpressure; the model checks each cycle.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: addr = 32'h100 + 32'($urandom_range(0, 63));
        6, 7:             addr = 32'hFF0 + 32'($urandom_range(0, 15));
        8:                addr = 32'h1000 + 32'($urandom_range(0, 15));
        default:          addr = $urandom;
      endcase
      doOp(addr, $urandom, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rd, er, lat);
      checkOutput("rand_latency", 32'(lat), 32'(LATENCY));
      n = $urandom_range(0, 2);
      repeat (n) @(posedge clk);
      #1;
    end
    randReady = 1'b0;
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
